// File: rtl/sdram_port_arbiter.sv
// Three-port round-robin arbiter in front of a single SDRAM controller port.
// One transaction in flight at a time; a watchdog aborts a stalled downstream request.
module sdram_port_arbiter #(
  parameter int AW     = 22,
  parameter int TO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [3*AW-1:0]   addr,
  input  logic [47:0]       wdata,
  input  logic [5:0]        sel,
  output logic [2:0]        ack,
  output logic [2:0]        err,
  output logic [15:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_sel,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Watchdog value seen in the last permitted WAIT cycle.
  localparam logic [15:0] WD_LAST = 16'(TO_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_last, r_grant, w_pick;
  logic [15:0] r_wd, r_rdata;
  logic        r_err, r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [1:0]  r_mem_sel;
  logic        w_start, w_done_ok, w_timeout;

  // Search order starts just after the last granted port, wrapping modulo 3.
  always_comb begin
    case (r_last)
      2'd0:    w_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    w_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: w_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (req != 3'b000) begin
        w_start     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (mem_ack) begin
        // mem_ack beats a coincident timeout.
        w_done_ok   = 1'b1;
        w_state_nxt = S_DONE;
      end else if (r_wd == WD_LAST) begin
        w_timeout   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    busy = (r_state != S_IDLE);
    ack  = (r_state == S_DONE) ? (3'b001 << r_grant) : 3'b000;
    err  = r_err ? ack : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_sel   <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_grant     <= 2'd0;
      r_last      <= 2'd2;
      r_wd        <= '0;
    end else if (w_start) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= we[w_pick];
      r_mem_addr  <= addr[int'(w_pick)*AW +: AW];
      r_mem_wdata <= wdata[int'(w_pick)*16 +: 16];
      r_mem_sel   <= sel[int'(w_pick)*2 +: 2];
      r_grant     <= w_pick;
      r_last      <= w_pick;
      r_err       <= 1'b0;
      r_wd        <= '0;
    end else if (w_done_ok) begin
      r_mem_req <= 1'b0;
      r_rdata   <= mem_rdata;
      r_err     <= 1'b0;
    end else if (w_timeout) begin
      r_mem_req <= 1'b0;
      r_rdata   <= 16'hFFFF;
      r_err     <= 1'b1;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + 16'd1;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_sel   = r_mem_sel;
  assign rdata     = r_rdata;
  assign grant     = r_grant;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin/timeout model.
module tb_sdram_port_arbiter;

  localparam int AW     = 22;
  localparam int TO_CYC = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req, we;
  logic [3*AW-1:0] addr;
  logic [47:0]     wdata;
  logic [5:0]      sel;
  logic [2:0]      ack, err;
  logic [15:0]     rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     mem_wdata;
  logic [1:0]      mem_sel;
  logic            mem_ack;
  logic [15:0]     mem_rdata;
  logic            busy;
  logic [1:0]      grant;

  logic [AW-1:0] p_addr[3];
  logic [15:0]   p_wdata[3];
  logic [1:0]    p_sel[3];

  assign addr  = {p_addr[2], p_addr[1], p_addr[0]};
  assign wdata = {p_wdata[2], p_wdata[1], p_wdata[0]};
  assign sel   = {p_sel[2], p_sel[1], p_sel[0]};

  sdram_port_arbiter #(.AW(AW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .sel(sel), .ack(ack), .err(err), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_last;
  int acks[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // First requesting port in order last+1, last+2, last+3 (mod 3).
  function automatic int model_pick(input int last, input logic [2:0] r);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic rand_port(input int n);
    p_addr[n]  = AW'($urandom);
    p_wdata[n] = 16'($urandom);
    p_sel[n]   = 2'($urandom);
    we[n]      = 1'($urandom);
  endtask

  // Starts at a negedge in IDLE, ends at the negedge of the IDLE cycle after DONE.
  // dly: WAIT cycle in which mem_ack is pulsed (0 or > TO_CYC means never).
  task automatic run_txn(input logic [2:0] r, input int dly, input logic [15:0] rd,
                         input bit drop, input bit scr);
    int p, hi, exp_hi;
    bit to;
    logic [AW+18:0] exp_cmd;
    logic [15:0] done_rdata;
    req    = r;
    p      = model_pick(m_last, r);
    m_last = p;
    exp_cmd = {we[p], p_sel[p], p_wdata[p], p_addr[p]};
    to     = (dly <= 0 || dly > TO_CYC);
    exp_hi = to ? TO_CYC : dly;
    hi     = 0;
    @(negedge clk);
    check("grant", 32'(grant), 32'(p));
    for (int c = 0; c < TO_CYC + 4; c++) begin
      if (mem_req !== 1'b1) break;
      hi++;
      check("mem_cmd", 32'({mem_we, mem_sel, mem_wdata}), 32'(exp_cmd[AW+18:AW]));
      check("mem_addr", 32'(mem_addr), 32'(exp_cmd[AW-1:0]));
      if (scr)
        for (int n = 0; n < 3; n++)
          if (n != p) begin
            rand_port(n);
            req[n] = 1'($urandom);
          end
      if (hi == dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    if (mem_req === 1'b1) check("wait_bound", 32'(mem_req), 32'(0));
    check("req_cycles", 32'(hi), 32'(exp_hi));
    check("ack", 32'(ack), 32'(1) << p);
    check("err", 32'(err), to ? (32'(1) << p) : 32'(0));
    check("busy_done", 32'(busy), 32'(1));
    if (to || !exp_cmd[AW+18]) check("rdata", 32'(rdata), to ? 32'hFFFF : 32'(rd));
    for (int n = 0; n < 3; n++) if (ack[n] === 1'b1) acks[n]++;
    done_rdata = rdata;
    if (drop) req[p] = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'($urandom);
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_after", 32'({busy, mem_req, ack, err}), 32'(0));
    check("rdata_hold", 32'(rdata), 32'(done_rdata));
  endtask

  initial begin
    logic [15:0] prev;
    rst_n = 1'b0;
    req = 3'b000;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    for (int n = 0; n < 3; n++) rand_port(n);
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd", 32'({mem_req, mem_we, mem_sel, mem_wdata}), 32'(0));
    check("rst_addr", 32'(mem_addr), 32'(0));
    check("rst_out", 32'({ack, err, busy, grant}), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    m_last = 2;
    rst_n  = 1'b1;

    // Single read from the CPU port.
    p_addr[0] = 22'h12345;
    we[0]     = 1'b0;
    run_txn(3'b001, 5, 16'hBEEF, 1'b1, 1'b0);

    // Round-robin with all ports held active and one-cycle downstream latency.
    for (int n = 0; n < 3; n++) acks[n] = 0;
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < 3; n++) rand_port(n);
      run_txn(3'b111, 1, 16'($urandom), 1'b0, 1'b0);
    end
    for (int n = 0; n < 3; n++) check("rr_share", 32'(acks[n]), 32'(2));

    // Timeout on the disk port, then a normal transaction.
    run_txn(3'b100, 0, 16'h0, 1'b1, 1'b0);
    run_txn(3'b100, 3, 16'h5A5A, 1'b1, 1'b0);

    // mem_ack coincides with the watchdog limit.
    we[1] = 1'b0;
    run_txn(3'b010, TO_CYC, 16'h1234, 1'b1, 1'b0);

    // Stray mem_ack in IDLE.
    req = 3'b000;
    prev = rdata;
    mem_ack = 1'b1;
    mem_rdata = 16'hC0DE;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_idle", 32'({busy, mem_req, ack, err}), 32'(0));
    check("stray_rdata", 32'(rdata), 32'(prev));

    // Reset in the middle of WAIT.
    req = 3'b010;
    @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b011;
    @(negedge clk);
    check("rst_wait_out", 32'({mem_req, ack, err, busy, grant}), 32'(0));
    @(negedge clk);
    check("rst_wait_ack", 32'(ack), 32'(0));
    rst_n  = 1'b1;
    m_last = 2;
    run_txn(3'b011, 2, 16'h7777, 1'b1, 1'b0);

    // Randomized traffic with idle gaps and bus scrambling on other ports.
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        req = 3'b000;
        @(negedge clk);
        check("gap_idle", 32'({busy, mem_req, ack}), 32'(0));
      end
      for (int n = 0; n < 3; n++) rand_port(n);
      run_txn(3'($urandom_range(1, 7)), int'($urandom_range(1, TO_CYC + 2)),
              16'($urandom), 1'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter AW, default 22, word-address width of every port.
REQ-002 Parameter TO_CYC, default 255, maximum cycles mem_req may wait for mem_ack before abort; legal range 2..65535.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 req  in  3  per-port request level; bit 0 CPU, bit 1 loader, bit 2 disk DMA.
REQ-006 we  in  3  per-port write enable, valid while req[n]=1.
REQ-007 addr  in  3*AW  per-port word address; port n at [n*AW +: AW].
REQ-008 wdata  in  48  per-port write data; port n at [n*16 +: 16].
REQ-009 sel  in  6  per-port byte lanes; port n at [n*2 +: 2].
REQ-010 ack  out  3  per-port completion pulse, one cycle.
REQ-011 err  out  3  per-port timeout flag, coincident with ack.
REQ-012 rdata  out  16  registered read data, shared by all ports, valid while any ack bit is 1.
REQ-013 mem_req  out  1  downstream request level to the SDRAM controller.
REQ-014 mem_we, mem_addr[AW-1:0], mem_wdata[15:0], mem_sel[1:0]  out  downstream command, registered, stable while mem_req=1.
REQ-015 mem_ack  in  1  downstream completion pulse; mem_rdata[15:0] in, valid with mem_ack.
REQ-016 busy  out  1  high in every state except IDLE; grant  out  2  index of the current/last granted port.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-018 In IDLE with req!=0, the block SHALL select the first set req bit in order (last+1, last+2, last+3) mod 3, latch that port's we/addr/wdata/sel into the mem_* registers, set grant and last to its index, and enter WAIT with mem_req=1 on the next cycle.
REQ-019 In IDLE with req==0, the block SHALL stay in IDLE with mem_req=0.
REQ-020 In WAIT, mem_req SHALL stay 1 and mem_* command SHALL not change until mem_ack=1 or timeout.
REQ-021 On mem_ack=1 in WAIT, the block SHALL clear mem_req, register mem_rdata into rdata, and enter DONE.
REQ-022 In DONE, ack[grant]=1 for exactly one cycle and all other ack bits SHALL be 0; next state IDLE.
REQ-023 A requester drops req[n] in the cycle ack[n] is seen; IDLE evaluation occurs one cycle after DONE, so a dropped request is never re-granted.
REQ-024 Minimum latency: req rising in cycle 0 gives mem_req=1 in cycle 1; mem_ack in cycle k gives ack in cycle k+1.
REQ-025 A 16-bit watchdog SHALL clear on entry to WAIT and increment each WAIT cycle without mem_ack; on reaching TO_CYC, the block SHALL clear mem_req, load rdata=16'hFFFF, and enter DONE with err[grant]=1 alongside ack[grant].
REQ-026 If mem_ack and the timeout coincide, mem_ack SHALL win (normal completion, err=0).
REQ-027 mem_ack received in IDLE or DONE SHALL be ignored, with no state or output change.
REQ-028 Changes to the req, addr, or data of non-granted ports during WAIT SHALL have no effect until the next IDLE evaluation.
REQ-029 Writes: rdata content during ack is don't-care unless err=1 (then 16'hFFFF).

Reset
REQ-030 With rst_n=0 at a clock edge, the next state SHALL be IDLE, with mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_sel=0, ack=0, err=0, rdata=0, busy=0, grant=0, last=2 (port 0 wins first), and watchdog=0.
REQ-031 Reset asserted during WAIT SHALL abort the transaction without issuing ack; mem_req SHALL be 0 in the cycle after the reset edge.

Verification
REQ-032 Single read: req=3'b001, addr0=0x12345, we=0; mem_ack after 5 cycles with mem_rdata=0xBEEF -> mem_addr=0x12345 and mem_req high 5 cycles; ack=3'b001 with rdata=0xBEEF one cycle later, err=0.
REQ-033 Round-robin: hold req=3'b111 with every mem_ack after 1 cycle -> grant sequence 0,1,2,0,1,2, and each port acked once per three transactions.
REQ-034 Timeout: TO_CYC=8, req=3'b100, mem_ack never asserted -> mem_req drops after 8 WAIT cycles; ack=3'b100, err=3'b100, rdata=0xFFFF; next request is serviced normally.
REQ-035 Coincidence: mem_ack on the same cycle the watchdog reaches TO_CYC -> err=0, rdata=mem_rdata.
REQ-036 Stray and reset: mem_ack pulsed in IDLE -> no ack. Separately, rst_n=0 mid-WAIT with req=3'b010 -> no ack, mem_req=0 next cycle, and after release port 0 (if requesting) is granted first.
